banked_tsmc_sram: RTL and testbench
===================================

BANKED_TSMC_SRAM -- requirements
Module: banked_tsmc_sram

Interface
REQ-001 SHALL have parameter WIDTH, default 128: data, mask and output width in bits (>=1).
REQ-002 SHALL have parameter NUM_ROWS, default 4096: total addressable rows (power of 2, >=2*NUM_BANKS).
REQ-003 SHALL have parameter NUM_BANKS, default 4: number of physical banks (power of 2, >=1).
REQ-004 SHALL have parameter OUT_REG, default 0: 1 adds one output pipeline stage.
REQ-005 SHALL have parameter CLEAR_ON_RESET, default 1: 1 zero-fills every row after reset.
REQ-006 SHALL have a derived constant AddressWidth = clog2(NUM_ROWS), not overridable.
REQ-007 CLK  input  1  single clock; all state updates on its rising edge.
REQ-008 RST  input  1  reset, synchronous, active-high.
REQ-009 CEB  input  1  chip enable, active low; a request is issued when CEB=0.
REQ-010 WEB  input  1  write enable, active low; 0=write, 1=read, sampled with CEB=0.
REQ-011 A  input  AddressWidth  row address.
REQ-012 D  input  WIDTH  write data.
REQ-013 M  input  WIDTH  write bit mask, 1=overwrite that bit.
REQ-014 Q  output  WIDTH  read data.
REQ-015 QV  output  1  one-cycle pulse marking new valid data on Q.
REQ-016 READY  output  1  high when requests are accepted (not clearing, not in reset).

Function
REQ-017 Bank select SHALL be A[clog2(NUM_BANKS)-1:0] (low-order interleave); bank row SHALL be the remaining upper bits; each bank SHALL hold NUM_ROWS/NUM_BANKS rows.
REQ-018 Only the selected bank SHALL be enabled for an accepted request; all other banks SHALL stay idle that cycle.
REQ-019 A request SHALL be accepted only when CEB=0 and READY=1; requests with READY=0 SHALL be dropped without effect on memory, Q or QV.
REQ-020 Accepted write SHALL set row := (D & M) | (row & ~M) at the rising edge of the request cycle; it SHALL NOT change Q and SHALL NOT pulse QV.
REQ-021 Accepted read SHALL present row contents on Q with QV=1 exactly 1+OUT_REG cycles after the request edge; QV SHALL be 0 in all other cycles.
REQ-022 Q SHALL hold its last value until the next read result; back-to-back reads (one per cycle, any bank mix) SHALL produce results in order at full throughput.
REQ-023 Read of a row in the cycle immediately after a write to it SHALL return the newly written data.
REQ-024 With OUT_REG=1, the bank select of each read SHALL be pipelined alongside the data so the correct bank is muxed to Q.
REQ-025 Controller SHALL have states RESET, CLEAR, IDLE: RST=1 -> RESET; RESET -> CLEAR when RST=0 and CLEAR_ON_RESET=1, else -> IDLE; CLEAR -> IDLE after last row written; IDLE stays until RST.
REQ-026 In CLEAR, a row counter SHALL start at 0, write zeros (full mask) to that row in all banks in parallel each cycle, and increment to NUM_ROWS/NUM_BANKS-1; CLEAR SHALL last exactly NUM_ROWS/NUM_BANKS cycles.
REQ-027 READY SHALL be 1 only in IDLE.
REQ-028 RST asserted during CLEAR SHALL abort it and restart the clear from row 0 after release.
REQ-029 RST asserted with reads in the output pipeline SHALL cancel them: no QV pulse SHALL appear for requests issued before or during reset.

Reset
REQ-030 While RST=1: Q=0, QV=0, READY=0, row counter=0, pipeline valid bits=0; no bank write except under CLEAR.
REQ-031 With CLEAR_ON_RESET=0, memory contents SHALL be unaffected by reset and READY SHALL rise in the first cycle after RST falls.

Verification
REQ-032 Defaults, RST high 2 cycles then low -> READY=0 for exactly 1+1024 cycles total after release (RESET+CLEAR), then 1; read of A=0x7FF -> Q=0, QV pulse 1 cycle later.
REQ-033 Write A=5 D=0xFF..FF M=0x00FF then read A=5 next cycle -> Q=0x00FF, QV on cycle +1 (OUT_REG=0) and +2 (OUT_REG=1).
REQ-034 Reads to A=0,1,2,3 on consecutive cycles after writing 0xA0..0xA3 -> Q sequence 0xA0,0xA1,0xA2,0xA3 on four consecutive QV pulses.
REQ-035 RST asserted at CLEAR row 500, released -> READY low for a fresh 1024 cycles; no accepted request in between changes memory.
REQ-036 Request with CEB=0 while READY=0 (write A=9 D=1 M=all-ones) -> later read of A=9 returns 0; no QV for the dropped request.
REQ-037 Read issued, RST asserted the next cycle (OUT_REG=1) -> QV never pulses for that read; Q=0.

Source files
------------

// File: rtl/banked_tsmc_sram.sv
// Banked single-port SRAM wrapper: low-order bank interleave, optional output
// register, and a reset-time zero-fill sequencer that clears all banks in parallel.

module banked_tsmc_sram_bank #(
  parameter int WIDTH = 8,
  parameter int ROWS  = 2,
  localparam int RW   = $clog2(ROWS)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en_i,
  input  logic             we_i,
  input  logic [RW-1:0]    addr_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH-1:0] dout_o
);
  logic [WIDTH-1:0] mem_q [ROWS];
  logic [WIDTH-1:0] dout_q;

  // Storage is never reset; writes are gated by the caller.
  always_ff @(posedge CLK) begin
    if (en_i && we_i) mem_q[addr_i] <= (d_i & m_i) | (mem_q[addr_i] & ~m_i);
  end

  always_ff @(posedge CLK) begin
    if (RST)               dout_q <= '0;
    else if (en_i && !we_i) dout_q <= mem_q[addr_i];
  end

  assign dout_o = dout_q;
endmodule

module banked_tsmc_sram #(
  parameter int WIDTH          = 128,
  parameter int NUM_ROWS       = 4096,
  parameter int NUM_BANKS      = 4,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1,
  localparam int AddressWidth  = $clog2(NUM_ROWS)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    CEB,
  input  logic                    WEB,
  input  logic [AddressWidth-1:0] A,
  input  logic [WIDTH-1:0]        D,
  input  logic [WIDTH-1:0]        M,
  output logic [WIDTH-1:0]        Q,
  output logic                    QV,
  output logic                    READY
);
  localparam int BankBits = $clog2(NUM_BANKS);
  localparam int SelW     = (BankBits > 0) ? BankBits : 1;
  localparam int BankRows = NUM_ROWS / NUM_BANKS;
  localparam int RowW     = AddressWidth - BankBits;
  localparam int STAGES   = (OUT_REG != 0) ? 1 : 0;
  localparam int VW       = STAGES + 1;

  typedef enum logic [1:0] {S_RESET, S_CLEAR, S_IDLE} state_e;

  state_e          state_q, state_d;
  logic [RowW-1:0] cnt_q, cnt_d;
  logic [SelW-1:0] sel, sel_q;
  logic [RowW-1:0] row;
  logic            acc_rd, acc_wr, clear_wr;
  logic [STAGES:0] vld_pipe;

  logic [NUM_BANKS-1:0]            bank_en;
  logic [NUM_BANKS-1:0][WIDTH-1:0] bank_dout;
  logic [WIDTH-1:0]                dout_sel;

  // ---- address split
  assign row = RowW'(A >> BankBits);
  if (BankBits > 0) begin : g_sel
    assign sel = A[SelW-1:0];
  end else begin : g_nosel
    assign sel = '0;
  end

  // ---- controller
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_RESET;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_RESET: begin
        cnt_d   = '0;
        state_d = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
      end
      S_CLEAR: begin
        if (cnt_q == RowW'(BankRows - 1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign READY    = (state_q == S_IDLE) && !RST;
  assign acc_rd   = !CEB && READY && WEB;
  assign acc_wr   = !CEB && READY && !WEB;
  assign clear_wr = (state_q == S_CLEAR) && !RST;

  // ---- banks: clear hits every bank at once, requests only the selected one
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    assign bank_en[b] = clear_wr || ((acc_rd || acc_wr) && (sel == SelW'(b)));
    banked_tsmc_sram_bank #(.WIDTH(WIDTH), .ROWS(BankRows)) u_bank (
      .CLK   (CLK),
      .RST   (RST),
      .en_i  (bank_en[b]),
      .we_i  (clear_wr || acc_wr),
      .addr_i(clear_wr ? cnt_q : row),
      .d_i   (clear_wr ? '0 : D),
      .m_i   (clear_wr ? '1 : M),
      .dout_o(bank_dout[b])
    );
  end

  // ---- read return pipeline
  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_pipe <= '0;
      sel_q    <= '0;
    end else begin
      vld_pipe <= VW'({vld_pipe, acc_rd});
      if (acc_rd) sel_q <= sel;
    end
  end

  assign dout_sel = bank_dout[sel_q];

  if (OUT_REG != 0) begin : g_oreg
    logic [WIDTH-1:0] q_q;
    always_ff @(posedge CLK) begin
      if (RST)              q_q <= '0;
      else if (vld_pipe[0]) q_q <= dout_sel;
    end
    assign Q = q_q;
  end else begin : g_noreg
    // Bank output registers hold until their next read, so Q holds too.
    assign Q = dout_sel;
  end

  assign QV = vld_pipe[STAGES];
endmodule

// File: tb/tb_banked_tsmc_sram.sv
// Directed bench: defaults with OUT_REG=0/1 side by side, plus a small
// CLEAR_ON_RESET=0 instance for reset-preserves-memory behaviour.

module tb_banked_tsmc_sram;
  localparam int W = 128;
  localparam logic [W-1:0] ONES = '1;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic         RST = 1'b1, CEB = 1'b1, WEB = 1'b1;
  logic [11:0]  A = '0;
  logic [W-1:0] D = '0, M = '0;
  logic [W-1:0] q0, q1;
  logic         qv0, qv1, rdy0, rdy1;

  logic       r2 = 1'b1, c2 = 1'b1, w2 = 1'b1;
  logic [3:0] a2 = '0;
  logic [7:0] d2 = '0, m2 = '0, q2;
  logic       qv2, rdy2;

  int total = 0, bad = 0;

  banked_tsmc_sram #(.OUT_REG(0)) dut0 (
    .CLK(CLK), .RST(RST), .CEB(CEB), .WEB(WEB), .A(A), .D(D), .M(M),
    .Q(q0), .QV(qv0), .READY(rdy0));

  banked_tsmc_sram #(.OUT_REG(1)) dut1 (
    .CLK(CLK), .RST(RST), .CEB(CEB), .WEB(WEB), .A(A), .D(D), .M(M),
    .Q(q1), .QV(qv1), .READY(rdy1));

  banked_tsmc_sram #(.WIDTH(8), .NUM_ROWS(16), .NUM_BANKS(2), .OUT_REG(0),
                     .CLEAR_ON_RESET(0)) dut2 (
    .CLK(CLK), .RST(r2), .CEB(c2), .WEB(w2), .A(a2), .D(d2), .M(m2),
    .Q(q2), .QV(qv2), .READY(rdy2));

  typedef struct {
    logic         ceb, web;
    logic [11:0]  a;
    logic [W-1:0] d, m;
    logic         qv0;
    logic [W-1:0] q0;
    logic         qv1;
    logic [W-1:0] q1;
  } vec_t;

  vec_t tbl[19];

  task automatic tick;
    @(posedge CLK);
    #2;
  endtask

  task automatic chk(input string n, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  task automatic setv(input int i, input logic ceb, input logic web, input logic [11:0] a,
                      input logic [W-1:0] d, input logic [W-1:0] m,
                      input logic eqv0, input logic [W-1:0] eq0,
                      input logic eqv1, input logic [W-1:0] eq1);
    tbl[i] = '{ceb, web, a, d, m, eqv0, eq0, eqv1, eq1};
  endtask

  // Counts not-ready cycles starting with the current one; also counts QV pulses.
  task automatic wait_ready(output int n, output int qvs);
    n = 0;
    qvs = 0;
    #1;
    while (!rdy0 && n < 3000) begin
      n++;
      tick();
      if (qv0 || qv1) qvs++;
    end
  endtask

  initial begin
    int n, qvs, hi;

    setv( 0, 0, 0, 12'h005, ONES,       W'(16'h00FF), 0, W'(0),     0, W'(0));
    setv( 1, 0, 1, 12'h005, '0,         '0,           1, W'(8'hFF), 0, W'(0));
    setv( 2, 1, 1, 12'h000, '0,         '0,           0, W'(8'hFF), 1, W'(8'hFF));
    setv( 3, 0, 0, 12'h000, W'(8'hA0),  ONES,         0, W'(8'hFF), 0, W'(8'hFF));
    setv( 4, 0, 0, 12'h001, W'(8'hA1),  ONES,         0, W'(8'hFF), 0, W'(8'hFF));
    setv( 5, 0, 0, 12'h002, W'(8'hA2),  ONES,         0, W'(8'hFF), 0, W'(8'hFF));
    setv( 6, 0, 0, 12'h003, W'(8'hA3),  ONES,         0, W'(8'hFF), 0, W'(8'hFF));
    setv( 7, 0, 1, 12'h000, '0,         '0,           1, W'(8'hA0), 0, W'(8'hFF));
    setv( 8, 0, 1, 12'h001, '0,         '0,           1, W'(8'hA1), 1, W'(8'hA0));
    setv( 9, 0, 1, 12'h002, '0,         '0,           1, W'(8'hA2), 1, W'(8'hA1));
    setv(10, 0, 1, 12'h003, '0,         '0,           1, W'(8'hA3), 1, W'(8'hA2));
    setv(11, 1, 1, 12'h000, '0,         '0,           0, W'(8'hA3), 1, W'(8'hA3));
    setv(12, 0, 0, 12'h006, W'(16'h1234), W'(16'hFF00), 0, W'(8'hA3), 0, W'(8'hA3));
    setv(13, 0, 1, 12'h006, '0,         '0,           1, W'(16'h1200), 0, W'(8'hA3));
    setv(14, 0, 0, 12'h006, W'(16'hFFFF), W'(16'h000F), 0, W'(16'h1200), 1, W'(16'h1200));
    setv(15, 0, 1, 12'h006, '0,         '0,           1, W'(16'h120F), 0, W'(16'h1200));
    setv(16, 1, 1, 12'h000, '0,         '0,           0, W'(16'h120F), 1, W'(16'h120F));
    setv(17, 0, 1, 12'h7FC, '0,         '0,           1, W'(0),     0, W'(16'h120F));
    setv(18, 1, 1, 12'h000, '0,         '0,           0, W'(0),     1, W'(0));

    // reset state
    tick(); tick();
    chk("rst_q0", q0, '0);     chk("rst_qv0", W'(qv0), '0); chk("rst_rdy0", W'(rdy0), '0);
    chk("rst_q1", q1, '0);     chk("rst_qv1", W'(qv1), '0); chk("rst_rdy1", W'(rdy1), '0);

    // release: RESET + full clear
    RST = 1'b0;
    wait_ready(n, qvs);
    chk("init_notready_cycles", W'(n), W'(1025));
    chk("init_qv_pulses", W'(qvs), '0);
    chk("init_rdy1", W'(rdy1), W'(1));

    // read of a cleared top row
    CEB = 1'b0; WEB = 1'b1; A = 12'h7FF;
    tick();
    CEB = 1'b1;
    chk("r7ff_qv0", W'(qv0), W'(1)); chk("r7ff_q0", q0, '0); chk("r7ff_qv1_early", W'(qv1), '0);
    tick();
    chk("r7ff_qv0_off", W'(qv0), '0); chk("r7ff_qv1", W'(qv1), W'(1)); chk("r7ff_q1", q1, '0);

    for (int i = 0; i < 19; i++) begin
      CEB = tbl[i].ceb; WEB = tbl[i].web; A = tbl[i].a; D = tbl[i].d; M = tbl[i].m;
      tick();
      chk($sformatf("vec%0d_qv0", i), W'(qv0), W'(tbl[i].qv0));
      chk($sformatf("vec%0d_q0", i),  q0,      tbl[i].q0);
      chk($sformatf("vec%0d_qv1", i), W'(qv1), W'(tbl[i].qv1));
      chk($sformatf("vec%0d_q1", i),  q1,      tbl[i].q1);
    end
    CEB = 1'b1;

    // reset, abort clear at row 500 while hammering a write that must be dropped
    RST = 1'b1;
    tick();
    RST = 1'b0; CEB = 1'b0; WEB = 1'b0; A = 12'h009; D = W'(1); M = ONES;
    hi = 0; qvs = 0;
    for (int k = 0; k < 501; k++) begin
      tick();
      if (rdy0 || rdy1) hi++;
      if (qv0 || qv1) qvs++;
    end
    chk("abort_ready_hi", W'(hi), '0);
    chk("abort_qv", W'(qvs), '0);
    RST = 1'b1;
    tick();
    chk("abort_rst_rdy", W'(rdy0), '0);
    RST = 1'b0;
    wait_ready(n, qvs);
    CEB = 1'b0; WEB = 1'b1; A = 12'h009;
    chk("reclear_cycles", W'(n), W'(1025));
    chk("reclear_qv", W'(qvs), '0);
    tick();
    CEB = 1'b1;
    chk("dropped_wr_qv0", W'(qv0), W'(1)); chk("dropped_wr_q0", q0, '0);
    tick();
    chk("dropped_wr_qv1", W'(qv1), W'(1)); chk("dropped_wr_q1", q1, '0);

    // read then reset next cycle: OUT_REG=1 result is cancelled
    CEB = 1'b0; WEB = 1'b0; A = 12'h000; D = W'(8'h77); M = ONES;
    tick();
    WEB = 1'b1;
    tick();
    CEB = 1'b1; RST = 1'b1;
    chk("cancel_qv0", W'(qv0), W'(1)); chk("cancel_q0", q0, W'(8'h77));
    chk("cancel_qv1_stage0", W'(qv1), '0);
    tick();
    chk("cancel_qv1", W'(qv1), '0); chk("cancel_q1", q1, '0);
    chk("cancel_q0_rst", q0, '0);   chk("cancel_qv0_rst", W'(qv0), '0);
    RST = 1'b0;
    wait_ready(n, qvs);
    chk("cancel_reclear_cycles", W'(n), W'(1025));
    chk("cancel_no_qv", W'(qvs), '0);
    chk("cancel_q1_after", q1, '0);

    // no-clear instance: fast ready, memory survives reset
    tick();
    chk("nc_rst_rdy", W'(rdy2), '0); chk("nc_rst_q", W'(q2), '0);
    r2 = 1'b0;
    #1;
    chk("nc_release_rdy", W'(rdy2), '0);
    tick();
    chk("nc_first_cycle_rdy", W'(rdy2), W'(1));
    c2 = 1'b0; w2 = 1'b0; a2 = 4'd3; d2 = 8'h5A; m2 = 8'hFF;
    tick();
    d2 = 8'hFF; m2 = 8'h0F;
    tick();
    c2 = 1'b1; r2 = 1'b1;
    tick();
    chk("nc_rst2_rdy", W'(rdy2), '0);
    tick();
    r2 = 1'b0;
    tick();
    chk("nc_rdy2", W'(rdy2), W'(1));
    c2 = 1'b0; w2 = 1'b1; a2 = 4'd3;
    tick();
    c2 = 1'b1;
    chk("nc_qv", W'(qv2), W'(1)); chk("nc_q", W'(q2), W'(8'h5F));
    tick();
    chk("nc_qv_off", W'(qv2), '0); chk("nc_q_hold", W'(q2), W'(8'h5F));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
